// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the IF/MA memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IACCESS = 2'd1,
        DACCESS = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        SIZE_NONE = 2'b00,
        SIZE_BYTE = 2'b01,
        SIZE_HALF = 2'b10,
        SIZE_WORD = 2'b11
    } mem_size_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_MA = 1'b1
    } grant_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam int unsigned TIMEOUT_DEFAULT   = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester (IF, MA) and memory-side bus of the arbiter; the arbiter takes the slave view.
interface mem_arbiter_if;

    logic        IF_REQ;
    logic [31:0] IF_ADDR;
    logic [31:0] IF_INSTR;
    logic        IF_VALID;
    logic        IF_STALL;

    logic [1:0]  MA_READ;
    logic [1:0]  MA_WRITE;
    logic [31:0] MA_ADDR;
    logic [31:0] MA_WDATA;
    logic [31:0] MA_RDATA;
    logic        MA_VALID;
    logic        MA_STALL;

    logic        MEM_REQ;
    logic        MEM_WE;
    logic [1:0]  MEM_SIZE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;
    logic        MEM_ACK;

    logic        ERR_TIMEOUT;

    modport slave (
        input  IF_REQ, IF_ADDR, MA_READ, MA_WRITE, MA_ADDR, MA_WDATA, MEM_RDATA, MEM_ACK,
        output IF_INSTR, IF_VALID, IF_STALL, MA_RDATA, MA_VALID, MA_STALL,
               MEM_REQ, MEM_WE, MEM_SIZE, MEM_ADDR, MEM_WDATA, ERR_TIMEOUT
    );

    modport master (
        output IF_REQ, IF_ADDR, MA_READ, MA_WRITE, MA_ADDR, MA_WDATA, MEM_RDATA, MEM_ACK,
        input  IF_INSTR, IF_VALID, IF_STALL, MA_RDATA, MA_VALID, MA_STALL,
               MEM_REQ, MEM_WE, MEM_SIZE, MEM_ADDR, MEM_WDATA, ERR_TIMEOUT
    );

endinterface

// File: rtl/arb_timeout_counter.sv
// Access watchdog: counts access cycles without ACK; reached fires on the cycle the count hits LIMIT.
module arb_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic reached
);

    localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + W'(1);
        end
    end

    // Combinational so the abort lands on the same edge the count would reach LIMIT.
    assign reached = enable && (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and memory access (MA).
// Define ARB_FAIR_EN for round-robin grant on contention; default is fixed MA priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEFAULT
) (
    input logic          CLK,
    input logic          RESET,
    mem_arbiter_if.slave bus
);

    arb_state_t  state_q, state_d;
    logic        mem_we_q;
    mem_size_t   mem_size_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [31:0] if_instr_q, ma_rdata_q;
    logic        if_valid_q, ma_valid_q, err_q;

    logic grant_if, grant_ma, done, timed_out, tmo_reached;
    logic ma_req, ma_is_write, if_pending, ma_pending, in_access;

    assign ma_is_write = |bus.MA_WRITE;
    assign ma_req      = ma_is_write | (|bus.MA_READ);
    // A requester seeing its VALID this cycle has been served; don't re-grant it.
    assign if_pending  = bus.IF_REQ & ~if_valid_q;
    assign ma_pending  = ma_req & ~ma_valid_q;
    assign in_access   = (state_q != IDLE);

    arb_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (CLK),
        .rst    (RESET),
        .clear  (grant_if | grant_ma),
        .enable (in_access & ~bus.MEM_ACK),
        .reached(tmo_reached)
    );

`ifdef ARB_FAIR_EN
    grant_t last_grant_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_grant_q <= GRANT_IF;
        end else if (grant_ma) begin
            last_grant_q <= GRANT_MA;
        end else if (grant_if) begin
            last_grant_q <= GRANT_IF;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_if  = 1'b0;
        grant_ma  = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef ARB_FAIR_EN
                if (ma_pending && (!if_pending || last_grant_q == GRANT_IF)) begin
                    grant_ma = 1'b1;
                end else if (if_pending) begin
                    grant_if = 1'b1;
                end
`else
                if (ma_pending) begin
                    grant_ma = 1'b1;
                end else if (if_pending) begin
                    grant_if = 1'b1;
                end
`endif
                if (grant_ma) begin
                    state_d = DACCESS;
                end else if (grant_if) begin
                    state_d = IACCESS;
                end
            end
            IACCESS, DACCESS: begin
                // ACK wins over a timeout landing in the same cycle.
                if (bus.MEM_ACK) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (tmo_reached) begin
                    timed_out = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem_we_q    <= 1'b0;
            mem_size_q  <= SIZE_NONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_instr_q  <= '0;
            ma_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            ma_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            ma_valid_q <= 1'b0;
            err_q      <= timed_out;
            if (grant_ma) begin
                mem_addr_q  <= bus.MA_ADDR;
                mem_wdata_q <= bus.MA_WDATA;
                mem_we_q    <= ma_is_write;
                mem_size_q  <= ma_is_write ? mem_size_t'(bus.MA_WRITE) : mem_size_t'(bus.MA_READ);
            end else if (grant_if) begin
                mem_addr_q  <= bus.IF_ADDR;
                mem_wdata_q <= '0;
                mem_we_q    <= 1'b0;
                mem_size_q  <= SIZE_WORD;
            end
            if (done || timed_out) begin
                if (state_q == IACCESS) begin
                    if_valid_q <= 1'b1;
                    if_instr_q <= done ? bus.MEM_RDATA : NOP_INSTR;
                end else begin
                    ma_valid_q <= 1'b1;
                    if (timed_out) begin
                        ma_rdata_q <= '0;
                    end else if (!mem_we_q) begin
                        ma_rdata_q <= bus.MEM_RDATA;
                    end
                end
            end
        end
    end

    assign bus.MEM_REQ     = in_access;
    assign bus.MEM_WE      = mem_we_q;
    assign bus.MEM_SIZE    = mem_size_q;
    assign bus.MEM_ADDR    = mem_addr_q;
    assign bus.MEM_WDATA   = mem_wdata_q;
    assign bus.IF_INSTR    = if_instr_q;
    assign bus.IF_VALID    = if_valid_q;
    assign bus.MA_RDATA    = ma_rdata_q;
    assign bus.MA_VALID    = ma_valid_q;
    assign bus.ERR_TIMEOUT = err_q;
    assign bus.IF_STALL    = if_pending;
    assign bus.MA_STALL    = ma_pending;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expectations follow ARB_FAIR_EN when the bench is built with it.
module tb_mem_arbiter;

    logic CLK = 1'b0;
    logic RESET;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] ma_rdata_exp;
    logic [31:0] first_addr, second_addr;
    logic        first_is_if;

    mem_arbiter_if bus();

    mem_arbiter #(
        .TIMEOUT_CYCLES(255),
        .NOP_INSTR     (32'h0000_0013)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        bus.IF_REQ    = 1'b0;
        bus.IF_ADDR   = '0;
        bus.MA_READ   = 2'b00;
        bus.MA_WRITE  = 2'b00;
        bus.MA_ADDR   = '0;
        bus.MA_WDATA  = '0;
        bus.MEM_RDATA = '0;
        bus.MEM_ACK   = 1'b0;
    endtask

    task automatic both_round(input int unsigned r);
        logic [31:0] ia;
        ia = 32'h200 + 32'(r * 4);
        bus.IF_REQ = 1'b1; bus.IF_ADDR = ia; bus.MA_READ = 2'b11; bus.MA_ADDR = 32'h100;
        settle();
        check("both_if_stall0", 32'(bus.IF_STALL), 32'd1);
        check("both_ma_stall0", 32'(bus.MA_STALL), 32'd1);
        cyc();
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'hA0 + r;
        settle();
        check("both_ma_first_addr", bus.MEM_ADDR, 32'h100);
        check("both_if_stall1", 32'(bus.IF_STALL), 32'd1);
        cyc();
        bus.MEM_ACK = 1'b0;
        settle();
        check("both_ma_valid", 32'(bus.MA_VALID), 32'd1);
        check("both_ma_rdata", bus.MA_RDATA, 32'hA0 + r);
        check("both_if_stall2", 32'(bus.IF_STALL), 32'd1);
        bus.MA_READ = 2'b00;
        cyc();
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'hB0 + r;
        settle();
        check("both_if_second_addr", bus.MEM_ADDR, ia);
        check("both_if_we", 32'(bus.MEM_WE), 32'd0);
        check("both_if_stall3", 32'(bus.IF_STALL), 32'd1);
        cyc();
        bus.MEM_ACK = 1'b0;
        settle();
        check("both_if_valid", 32'(bus.IF_VALID), 32'd1);
        check("both_if_instr", bus.IF_INSTR, 32'hB0 + r);
        check("both_if_stall4", 32'(bus.IF_STALL), 32'd0);
        bus.IF_REQ = 1'b0;
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        RESET = 1'b1;
        cyc();
        cyc();
        settle();
        check("rst_mem_req", 32'(bus.MEM_REQ), 32'd0);
        check("rst_mem_we", 32'(bus.MEM_WE), 32'd0);
        check("rst_mem_size", 32'(bus.MEM_SIZE), 32'd0);
        check("rst_mem_addr", bus.MEM_ADDR, 32'd0);
        check("rst_mem_wdata", bus.MEM_WDATA, 32'd0);
        check("rst_if_valid", 32'(bus.IF_VALID), 32'd0);
        check("rst_ma_valid", 32'(bus.MA_VALID), 32'd0);
        check("rst_err", 32'(bus.ERR_TIMEOUT), 32'd0);
        check("rst_if_instr", bus.IF_INSTR, 32'd0);
        check("rst_ma_rdata", bus.MA_RDATA, 32'd0);
        RESET = 1'b0;
        cyc();

        // Minimum-latency fetch
        bus.IF_REQ = 1'b1; bus.IF_ADDR = 32'h40;
        settle();
        check("lat_c0_mem_req", 32'(bus.MEM_REQ), 32'd0);
        check("lat_c0_if_stall", 32'(bus.IF_STALL), 32'd1);
        cyc();
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h0050_0093;
        settle();
        check("lat_c1_mem_req", 32'(bus.MEM_REQ), 32'd1);
        check("lat_c1_mem_addr", bus.MEM_ADDR, 32'h40);
        check("lat_c1_mem_size", 32'(bus.MEM_SIZE), 32'd3);
        check("lat_c1_if_stall", 32'(bus.IF_STALL), 32'd1);
        cyc();
        bus.MEM_ACK = 1'b0;
        settle();
        check("lat_c2_if_valid", 32'(bus.IF_VALID), 32'd1);
        check("lat_c2_if_instr", bus.IF_INSTR, 32'h0050_0093);
        check("lat_c2_mem_req", 32'(bus.MEM_REQ), 32'd0);
        check("lat_c2_if_stall", 32'(bus.IF_STALL), 32'd0);
        bus.IF_REQ = 1'b0;
        cyc();
        settle();
        check("lat_c3_if_valid", 32'(bus.IF_VALID), 32'd0);
        check("lat_c3_mem_req", 32'(bus.MEM_REQ), 32'd0);

        // Simultaneous requests, three rounds: MA then IF each time
        for (int unsigned r = 0; r < 3; r++) begin
            both_round(r);
        end

        // Lone MA byte read, then both pending: fair grants IF (last was MA), fixed grants MA
        bus.MA_READ = 2'b01; bus.MA_ADDR = 32'h300;
        cyc();
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h55;
        settle();
        check("lone_ma_size", 32'(bus.MEM_SIZE), 32'd1);
        cyc();
        bus.MEM_ACK = 1'b0;
        settle();
        check("lone_ma_valid", 32'(bus.MA_VALID), 32'd1);
        check("lone_ma_rdata", bus.MA_RDATA, 32'h55);
        bus.MA_READ = 2'b00;
        cyc();
`ifdef ARB_FAIR_EN
        first_is_if = 1'b1; first_addr = 32'h44;  second_addr = 32'h304;
        ma_rdata_exp = 32'h77;
`else
        first_is_if = 1'b0; first_addr = 32'h304; second_addr = 32'h44;
        ma_rdata_exp = 32'h66;
`endif
        bus.IF_REQ = 1'b1; bus.IF_ADDR = 32'h44; bus.MA_READ = 2'b10; bus.MA_ADDR = 32'h304;
        cyc();
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h66;
        settle();
        check("mix_first_addr", bus.MEM_ADDR, first_addr);
        cyc();
        bus.MEM_ACK = 1'b0;
        settle();
        check("mix_first_if_valid", 32'(bus.IF_VALID), 32'(first_is_if));
        check("mix_first_ma_valid", 32'(bus.MA_VALID), 32'(!first_is_if));
        check("mix_first_data", first_is_if ? bus.IF_INSTR : bus.MA_RDATA, 32'h66);
        if (first_is_if) bus.IF_REQ = 1'b0; else bus.MA_READ = 2'b00;
        cyc();
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h77;
        settle();
        check("mix_second_addr", bus.MEM_ADDR, second_addr);
        cyc();
        bus.MEM_ACK = 1'b0;
        settle();
        check("mix_second_if_valid", 32'(bus.IF_VALID), 32'(!first_is_if));
        check("mix_second_ma_valid", 32'(bus.MA_VALID), 32'(first_is_if));
        check("mix_second_data", first_is_if ? bus.MA_RDATA : bus.IF_INSTR, 32'h77);
        bus.IF_REQ = 1'b0; bus.MA_READ = 2'b00;
        cyc();

        // Read+write together is a write; inputs changed mid-access must not leak through
        bus.MA_READ = 2'b01; bus.MA_WRITE = 2'b11; bus.MA_ADDR = 32'h500; bus.MA_WDATA = 32'h1234_5678;
        cyc();
        bus.MA_ADDR = 32'hFFF0; bus.MA_WDATA = 32'h0;
        settle();
        check("wr_mem_we", 32'(bus.MEM_WE), 32'd1);
        check("wr_mem_size", 32'(bus.MEM_SIZE), 32'd3);
        check("wr_mem_addr_held", bus.MEM_ADDR, 32'h500);
        check("wr_mem_wdata_held", bus.MEM_WDATA, 32'h1234_5678);
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'hBAD0_BAD0;
        cyc();
        bus.MEM_ACK = 1'b0;
        settle();
        check("wr_ma_valid", 32'(bus.MA_VALID), 32'd1);
        check("wr_ma_rdata_kept", bus.MA_RDATA, ma_rdata_exp);
        bus.MA_READ = 2'b00; bus.MA_WRITE = 2'b00;
        cyc();

        // ACK while idle is ignored
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h11;
        cyc();
        bus.MEM_ACK = 1'b0;
        settle();
        check("idle_ack_if_valid", 32'(bus.IF_VALID), 32'd0);
        check("idle_ack_ma_valid", 32'(bus.MA_VALID), 32'd0);
        check("idle_ack_mem_req", 32'(bus.MEM_REQ), 32'd0);
        cyc();

        // Write timeout after 255 access cycles, late ACK ignored
        bus.MA_WRITE = 2'b10; bus.MA_WDATA = 32'hDEAD_BEEF; bus.MA_ADDR = 32'h600;
        for (int unsigned k = 1; k <= 255; k++) begin
            cyc();
            if (k == 1) begin
                settle();
                check("tmo_c1_mem_req", 32'(bus.MEM_REQ), 32'd1);
                check("tmo_c1_mem_size", 32'(bus.MEM_SIZE), 32'd2);
                check("tmo_c1_mem_wdata", bus.MEM_WDATA, 32'hDEAD_BEEF);
            end
            if (k == 255) begin
                settle();
                check("tmo_c255_err", 32'(bus.ERR_TIMEOUT), 32'd0);
                check("tmo_c255_mem_req", 32'(bus.MEM_REQ), 32'd1);
                check("tmo_c255_ma_stall", 32'(bus.MA_STALL), 32'd1);
            end
        end
        cyc();
        settle();
        check("tmo_err_pulse", 32'(bus.ERR_TIMEOUT), 32'd1);
        check("tmo_mem_req_drop", 32'(bus.MEM_REQ), 32'd0);
        check("tmo_ma_valid", 32'(bus.MA_VALID), 32'd1);
        check("tmo_ma_rdata_zero", bus.MA_RDATA, 32'd0);
        check("tmo_ma_stall", 32'(bus.MA_STALL), 32'd0);
        bus.MA_WRITE = 2'b00;
        cyc();
        settle();
        check("tmo_err_one_cycle", 32'(bus.ERR_TIMEOUT), 32'd0);
        check("tmo_ma_valid_one_cycle", 32'(bus.MA_VALID), 32'd0);
        repeat (42) cyc();
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'hCAFE_F00D;
        cyc();
        bus.MEM_ACK = 1'b0;
        settle();
        check("late_ack_ma_valid", 32'(bus.MA_VALID), 32'd0);
        check("late_ack_err", 32'(bus.ERR_TIMEOUT), 32'd0);
        check("late_ack_ma_rdata", bus.MA_RDATA, 32'd0);
        cyc();

        // ACK in the very cycle the limit is reached completes normally
        bus.MA_READ = 2'b11; bus.MA_ADDR = 32'h700;
        for (int unsigned k = 1; k <= 255; k++) begin
            cyc();
            if (k == 255) begin
                bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h77;
            end
        end
        cyc();
        bus.MEM_ACK = 1'b0;
        settle();
        check("edge_ack_err", 32'(bus.ERR_TIMEOUT), 32'd0);
        check("edge_ack_ma_valid", 32'(bus.MA_VALID), 32'd1);
        check("edge_ack_ma_rdata", bus.MA_RDATA, 32'h77);
        bus.MA_READ = 2'b00;
        cyc();

        // Fetch timeout returns NOP
        bus.IF_REQ = 1'b1; bus.IF_ADDR = 32'h80;
        repeat (255) cyc();
        cyc();
        settle();
        check("if_tmo_err", 32'(bus.ERR_TIMEOUT), 32'd1);
        check("if_tmo_valid", 32'(bus.IF_VALID), 32'd1);
        check("if_tmo_nop", bus.IF_INSTR, 32'h0000_0013);
        bus.IF_REQ = 1'b0;
        cyc();

        // Reset in the 3rd IACCESS cycle, ACK afterwards
        bus.IF_REQ = 1'b1; bus.IF_ADDR = 32'h90;
        cyc();
        cyc();
        cyc();
        settle();
        check("mid_rst_in_access", 32'(bus.MEM_REQ), 32'd1);
        RESET = 1'b1; bus.IF_REQ = 1'b0;
        cyc();
        RESET = 1'b0; bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h99;
        settle();
        check("mid_rst_mem_req", 32'(bus.MEM_REQ), 32'd0);
        check("mid_rst_mem_addr", bus.MEM_ADDR, 32'd0);
        check("mid_rst_mem_size", 32'(bus.MEM_SIZE), 32'd0);
        check("mid_rst_if_valid", 32'(bus.IF_VALID), 32'd0);
        check("mid_rst_if_instr", bus.IF_INSTR, 32'd0);
        check("mid_rst_ma_rdata", bus.MA_RDATA, 32'd0);
        check("mid_rst_err", 32'(bus.ERR_TIMEOUT), 32'd0);
        cyc();
        bus.MEM_ACK = 1'b0;
        settle();
        check("post_rst_if_valid", 32'(bus.IF_VALID), 32'd0);
        check("post_rst_if_instr", bus.IF_INSTR, 32'd0);
        check("post_rst_mem_req", 32'(bus.MEM_REQ), 32'd0);
        check("post_rst_err", 32'(bus.ERR_TIMEOUT), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles an access waits for MEM_ACK before it is aborted.
REQ-002 Parameter NOP_INSTR, default 32'h00000013: instruction returned to IF on a timed-out fetch.
REQ-003 Ports, clock and reset first (name, direction, width, meaning):
- CLK in 1: the single clock.
- RESET in 1: synchronous, active-high reset.
- IF_REQ in 1: fetch request.
- IF_ADDR in 32: fetch address.
- IF_INSTR out 32: fetched instruction.
- IF_VALID out 1: one-cycle pulse marking IF_INSTR valid.
- IF_STALL out 1: freezes the PC and IF_ID register.
- MA_READ in 2: load size (00 none, 01 byte, 10 half, 11 word).
- MA_WRITE in 2: store size, same encoding as MA_READ.
- MA_ADDR in 32: data address.
- MA_WDATA in 32: store data.
- MA_RDATA out 32: load data.
- MA_VALID out 1: one-cycle pulse marking load/store completion.
- MA_STALL out 1: freezes the whole pipeline.
- MEM_REQ out 1: memory access active.
- MEM_WE out 1: access is a write.
- MEM_SIZE out 2: access size.
- MEM_ADDR out 32: memory address.
- MEM_WDATA out 32: memory write data.
- MEM_RDATA in 32: memory read data.
- MEM_ACK in 1: one-cycle pulse marking access completion.
- ERR_TIMEOUT out 1: one-cycle pulse on an aborted access.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, IACCESS and DACCESS.
REQ-005 An MA request is present when MA_READ!=0 or MA_WRITE!=0; when both fields are nonzero the access is a write with size MA_WRITE.
REQ-006 In IDLE, a pending MA request SHALL move the FSM to DACCESS; otherwise IF_REQ SHALL move it to IACCESS; otherwise it stays in IDLE.
REQ-007 On each grant edge, address, size, write enable and write data SHALL be captured into registers, and MEM_* SHALL be driven only from those registers.
REQ-008 MEM_REQ SHALL be 1 in both access states and 0 in IDLE; later changes on requester inputs SHALL NOT affect an access in flight.
REQ-009 On MEM_ACK in an access state, the FSM SHALL return to IDLE at the next edge.
- In the same edge, MEM_RDATA SHALL be registered into IF_INSTR or MA_RDATA.
- The matching *_VALID SHALL be 1 for exactly the following cycle.
- MA_RDATA SHALL be left unchanged on a write.
REQ-010 Minimum latency, with MEM_ACK in the first access cycle: request at cycle 0, MEM_REQ at cycle 1, VALID at cycle 2, next grant evaluated at cycle 2.
REQ-011 IF_STALL SHALL equal IF_REQ & ~IF_VALID, and MA_STALL SHALL equal (MA request present) & ~MA_VALID; both are combinational from registered state.
REQ-012 MEM_ACK received in IDLE SHALL be ignored.
REQ-013 The timeout counter SHALL clear on every grant and increment each access cycle without MEM_ACK; on reaching TIMEOUT_CYCLES:
- The FSM SHALL return to IDLE and drop MEM_REQ.
- ERR_TIMEOUT SHALL pulse for one cycle.
- The requester SHALL receive VALID with NOP_INSTR (IF) or 0 (MA).
REQ-014 MEM_ACK arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL take priority: normal completion, no error.

Reset
REQ-015 RESET SHALL set:
- state to IDLE;
- MEM_REQ, MEM_WE, IF_VALID, MA_VALID and ERR_TIMEOUT to 0;
- MEM_SIZE to 00;
- MEM_ADDR, MEM_WDATA, IF_INSTR and MA_RDATA to 0;
- the counter to 0 and last_grant to IF.
REQ-016 RESET asserted mid-access SHALL abort the access, with no VALID or ERR pulse; a MEM_ACK arriving after reset SHALL be ignored.

Configuration
REQ-017 With ARB_FAIR_EN defined, when both requesters are pending in IDLE, the grant SHALL go to the requester not granted last (last_grant flop); a lone requester SHALL always be granted.
REQ-018 Without ARB_FAIR_EN, MA SHALL have fixed priority as in REQ-006, and the last_grant flop SHALL NOT be present.

Structure
REQ-019 A shared header SHALL hold the state encodings (IDLE=2'd0, IACCESS=2'd1, DACCESS=2'd2), the size encodings and the NOP_INSTR default.
REQ-020 The timeout counter SHALL be a sub-module named arb_timeout_counter, with clear, enable and reached ports.

Verification
REQ-021 IF_REQ=1, IF_ADDR=0x40, MEM_ACK on the first access cycle with MEM_RDATA=0x00500093 -> MEM_REQ at cycle 1, IF_VALID and IF_INSTR=0x00500093 at cycle 2, IF_STALL high at cycles 0-1.
REQ-022 IF_REQ and MA_READ=11 (addr 0x100) both raised in the same cycle, fixed priority -> DACCESS first, then IACCESS; IF_STALL high throughout.
REQ-023 Same stimulus as REQ-022, repeated three times, with ARB_FAIR_EN -> grants alternate MA, IF, MA, IF, ...
REQ-024 MA_WRITE=10, MA_WDATA=0xDEADBEEF, MEM_ACK withheld for 300 cycles, TIMEOUT_CYCLES=255 -> ERR_TIMEOUT pulse after 255 access cycles, MEM_REQ drops, MA_VALID with MA_RDATA=0, the late ACK is ignored.
REQ-025 RESET asserted in the 3rd cycle of IACCESS, then MEM_ACK next cycle -> IDLE, no IF_VALID, all outputs at their reset values.
REQ-026 MA_READ=01 and MA_WRITE=11 together -> MEM_WE=1, MEM_SIZE=11.
